// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path:
//   - rx_state_e     : receive controller state encoding (3-bit binary)
//   - EVEN / ODD     : parity_type values
//   - MAX_DATA_BITS  : widest supported data field
//   - majority3      : 2-of-3 vote used by the bit-centre sampler
//   - expected_parity: parity bit expected for a data field
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    localparam int MAX_DATA_BITS = 9;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Unused upper bits of data must be zero so they do not disturb the XOR.
    function automatic logic expected_parity(input logic [MAX_DATA_BITS-1:0] data,
                                             input logic ptype);
        return (^data) ^ (ptype == ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Bit-centre sampler: two capture flops taken one cycle apart, combined with
// the live line value into a 2-of-3 majority vote. A single-cycle glitch on
// the line around the bit centre is therefore masked.
// Ports:
//   clk, arst_n        : clock, asynchronous active-low reset
//   rx_in              : synchronised serial line
//   cap_a_en, cap_b_en : capture strobes for the first and second sample
//   vote               : majority of both captures and the current rx_in
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic clk,
    input  logic arst_n,
    input  logic rx_in,
    input  logic cap_a_en,
    input  logic cap_b_en,
    output logic vote
);

    logic cap_a_r;
    logic cap_b_r;

    // Capture flops; reset to the idle line level.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cap_a_r <= 1'b1;
            cap_b_r <= 1'b1;
        end else begin
            if (cap_a_en) begin
                cap_a_r <= rx_in;
            end
            if (cap_b_en) begin
                cap_b_r <= rx_in;
            end
        end
    end

    assign vote = majority3(cap_a_r, cap_b_r, rx_in);

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// UART receive frame sequencer. Started by a one-cycle falling-edge pulse,
// it counts PRESCALE oversampling clocks per bit, votes at each bit centre,
// rejects glitch starts, shifts data LSB first, optionally checks parity and
// checks the stop bit, then presents the byte with a one-cycle valid pulse.
//
// Build option: define UART_RX_PARITY_EN to build the PARITY state and the
// parity check. Without it parity_en/parity_type are ignored and parity_err
// is constant 0.
//
// Parameters: DATA_BITS (5..9), PRESCALE (even, >= 6)
// Ports:
//   clk, arst_n  : oversampling clock, asynchronous active-low reset
//   rx_in        : synchronised serial line (idles high)
//   start        : falling-edge pulse from the edge detector
//   parity_en    : parity bit follows data (latched when a frame starts)
//   parity_type  : 0 even, 1 odd (latched when a frame starts)
//   rx_data      : data of the last error-free frame
//   data_valid   : one-cycle pulse for an error-free frame
//   parity_err   : last completed frame had a parity mismatch
//   stop_err     : last completed frame had a 0 stop bit
//   busy         : high whenever a frame is being received
// -----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PRESCALE  = 8
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 rx_in,
    input  logic                 start,
    input  logic                 parity_en,
    input  logic                 parity_type,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 stop_err,
    output logic                 busy
);

    localparam int S    = PRESCALE / 2;
    localparam int EC_W = $clog2(PRESCALE);
    localparam int BC_W = $clog2(DATA_BITS);

    localparam logic [EC_W-1:0] EC_ONE   = EC_W'(1);
    localparam logic [EC_W-1:0] EC_CAP_A = EC_W'(S - 1);
    localparam logic [EC_W-1:0] EC_CAP_B = EC_W'(S);
    localparam logic [EC_W-1:0] EC_VOTE  = EC_W'(S + 1);
    localparam logic [EC_W-1:0] EC_LAST  = EC_W'(PRESCALE - 1);
    localparam logic [BC_W-1:0] BC_ONE   = BC_W'(1);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(DATA_BITS - 1);

    rx_state_e            state_r;
    logic [EC_W-1:0]      ec_r;
    logic [BC_W-1:0]      bc_r;
    logic [DATA_BITS-1:0] shift_r;

    logic vote_s;
    logic vote_tick_s;
    logic ec_wrap_s;
    logic cap_a_en_s;
    logic cap_b_en_s;
    logic frame_ok_s;

    assign vote_tick_s = (state_r != IDLE) && (ec_r == EC_VOTE);
    assign ec_wrap_s   = (ec_r == EC_LAST);
    assign cap_a_en_s  = (state_r != IDLE) && (ec_r == EC_CAP_A);
    assign cap_b_en_s  = (state_r != IDLE) && (ec_r == EC_CAP_B);

    uart_rx_sampler u_sampler (
        .clk      (clk),
        .arst_n   (arst_n),
        .rx_in    (rx_in),
        .cap_a_en (cap_a_en_s),
        .cap_b_en (cap_b_en_s),
        .vote     (vote_s)
    );

`ifdef UART_RX_PARITY_EN
    logic                     par_en_r;
    logic                     par_type_r;
    logic                     par_fail_r;
    logic                     exp_par_s;
    logic [MAX_DATA_BITS-1:0] data_ext_s;

    // Expected parity bit over the assembled data field.
    always_comb begin
        data_ext_s                  = '0;
        data_ext_s[DATA_BITS-1:0]   = shift_r;
        exp_par_s                   = expected_parity(data_ext_s, par_type_r);
    end

    assign frame_ok_s = vote_s & ~par_fail_r;
`else
    logic unused_parity_s;
    assign unused_parity_s = parity_en ^ parity_type;
    assign frame_ok_s      = vote_s;
    assign parity_err      = 1'b0;
`endif

    // Frame sequencer with counters and registered outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r    <= IDLE;
            ec_r       <= '0;
            bc_r       <= '0;
            shift_r    <= '0;
            rx_data    <= '0;
            data_valid <= 1'b0;
            stop_err   <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_r   <= 1'b0;
            par_type_r <= EVEN;
            par_fail_r <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            if (state_r != IDLE) begin
                ec_r <= ec_wrap_s ? '0 : ec_r + EC_ONE;
            end
            case (state_r)
                IDLE: begin
                    ec_r <= '0;
                    bc_r <= '0;
                    if (start) begin
                        // start coincides with the first low cycle, so the
                        // next cycle is already ec = 1 of the start bit.
                        state_r    <= START;
                        ec_r       <= EC_ONE;
                        busy       <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        par_en_r   <= parity_en;
                        par_type_r <= parity_type;
                        par_fail_r <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (vote_tick_s && vote_s) begin
                        state_r <= IDLE;
                        ec_r    <= '0;
                        busy    <= 1'b0;
                    end else if (ec_wrap_s) begin
                        state_r <= DATA;
                        bc_r    <= '0;
                    end
                end
                DATA: begin
                    if (vote_tick_s) begin
                        shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
                    end
                    if (ec_wrap_s) begin
                        if (bc_r == BC_LAST) begin
                            bc_r <= '0;
`ifdef UART_RX_PARITY_EN
                            state_r <= par_en_r ? PARITY : STOP;
`else
                            state_r <= STOP;
`endif
                        end else begin
                            bc_r <= bc_r + BC_ONE;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (vote_tick_s) begin
                        par_fail_r <= (vote_s != exp_par_s);
                    end
                    if (ec_wrap_s) begin
                        state_r <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Leave at the stop-bit centre so a start edge at the end
                    // of the stop bit is never missed.
                    if (vote_tick_s) begin
                        state_r  <= IDLE;
                        ec_r     <= '0;
                        busy     <= 1'b0;
                        stop_err <= ~vote_s;
`ifdef UART_RX_PARITY_EN
                        parity_err <= par_fail_r;
`endif
                        if (frame_ok_s) begin
                            rx_data    <= shift_r;
                            data_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ec_r    <= '0;
                    bc_r    <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Self-checking bench for uart_rx_ctrl (DATA_BITS 8, PRESCALE 8). Frames are
// driven cycle by cycle; expected good frames are queued when driven and
// popped when data_valid is seen.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int DB = 8;
    localparam int PS = 8;
    localparam int S  = PS / 2;

    logic          clk         = 1'b0;
    logic          arst_n      = 1'b0;
    logic          rx_in       = 1'b1;
    logic          start       = 1'b0;
    logic          parity_en   = 1'b0;
    logic          parity_type = 1'b0;
    logic [DB-1:0] rx_data;
    logic          data_valid;
    logic          parity_err;
    logic          stop_err;
    logic          busy;

    typedef struct {
        logic [DB-1:0] data;
        int            at;
    } exp_t;

    exp_t exp_q[$];
    int   valid_cyc_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   tcyc  = 0;

    uart_rx_ctrl #(.DATA_BITS(DB), .PRESCALE(PS)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .rx_in       (rx_in),
        .start       (start),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .rx_data     (rx_data),
        .data_valid  (data_valid),
        .parity_err  (parity_err),
        .stop_err    (stop_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            rx_in = 1'b1;
            tcyc++;
        end
    endtask

    // One frame: outputs are sampled at each negedge (cycle c) and the inputs
    // for cycle c are then driven. rst_cyc >= 0 pulses arst_n mid-frame.
    task automatic send_frame(input logic [DB-1:0] data, input bit par_on,
                              input bit ptype, input bit par_flip,
                              input bit stop_bit, input bit glitch,
                              input int corrupt_cyc, input int rst_cyc);
        logic [15:0]   bits;
        bit            pe_eff;
        int            nb, len, done;
        bit            exp_perr, exp_serr, exp_valid;
        logic [DB-1:0] exp_rx;
        logic [DB-1:0] prev_rx;
        logic          prev_perr, prev_serr;
        exp_t          e;
`ifdef UART_RX_PARITY_EN
        pe_eff = par_on;
`else
        pe_eff = 1'b0;
`endif
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) bits[1+i] = data[i];
        if (pe_eff) bits[1+DB] = (^data) ^ ptype ^ par_flip;
        nb = 1 + DB + (pe_eff ? 1 : 0);
        bits[nb] = stop_bit;
        len  = glitch ? 16 : (nb + 1) * PS;
        done = glitch ? S + 2 : nb * PS + S + 2;
        exp_perr  = pe_eff && par_flip;
        exp_serr  = !stop_bit;
        exp_valid = !glitch && (rst_cyc < 0) && !exp_perr && !exp_serr;
        prev_rx   = rx_data;
        prev_perr = parity_err;
        prev_serr = stop_err;
        if (exp_valid) exp_q.push_back('{data, done});
        parity_en   = par_on;
        parity_type = ptype;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (data_valid === 1'b1) begin
                valid_cyc_q.push_back(tcyc);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_valid: data_valid at cycle %0d rx_data=%h, none required", c, rx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_data !== e.data || c != e.at) begin
                        n_err++;
                        $display("FAIL valid_frame: got data %h at cycle %0d, want %h at cycle %0d", rx_data, c, e.data, e.at);
                    end
                end
            end
            if (rst_cyc < 0 && (c == 1 || c == done - 1 || c == done)) begin
                n_cmp++;
                if (busy !== (c != done)) begin
                    n_err++;
                    $display("FAIL busy_c%0d: got %b want %b", c, busy, (c != done));
                end
            end
            if (rst_cyc >= 0 && c == rst_cyc + 2) begin
                n_cmp++;
                if ({rx_data, data_valid, parity_err, stop_err, busy} !== '0) begin
                    n_err++;
                    $display("FAIL in_reset: got rx_data=%h dv=%b pe=%b se=%b busy=%b want all 0", rx_data, data_valid, parity_err, stop_err, busy);
                end
            end
            start = (c == 0);
            rx_in = glitch ? (c >= 3) : bits[c / PS];
            if (c == corrupt_cyc) rx_in = ~rx_in;
            if (c == rst_cyc) arst_n = 1'b0;
            if (rst_cyc >= 0 && c == rst_cyc + 4) arst_n = 1'b1;
            tcyc++;
        end
        if (rst_cyc >= 0) begin
            exp_rx = '0; exp_perr = 1'b0; exp_serr = 1'b0;
        end else if (glitch) begin
            exp_rx = prev_rx; exp_perr = prev_perr; exp_serr = prev_serr;
        end else begin
            exp_rx = exp_valid ? data : prev_rx;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_valid: %0d pending frame(s), want 0 (data %h)", exp_q.size(), data);
            exp_q.delete();
        end
        n_cmp++;
        if (rx_data !== exp_rx || parity_err !== exp_perr || stop_err !== exp_serr) begin
            n_err++;
            $display("FAIL frame_outputs: got rx=%h pe=%b se=%b want rx=%h pe=%b se=%b",
                     rx_data, parity_err, stop_err, exp_rx, exp_perr, exp_serr);
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rx_data, data_valid, parity_err, stop_err, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got rx=%h dv=%b pe=%b se=%b busy=%b want all 0", rx_data, data_valid, parity_err, stop_err, busy);
        end
        arst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        idle(3);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        for (int i = 0; i < 3; i++) begin
            idle(2);
            send_frame(DB'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        end
        idle(3);
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        idle(3);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
        idle(3);
        send_frame(8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
        idle(3);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1, -1);
        idle(3);
`else
        // parity_en/parity_type must have no effect in this build.
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
        idle(3);
`endif
        send_frame(8'h69, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        idle(3);
    endtask

    task automatic test_stop_err();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        idle(6);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        idle(3);
    endtask

    task automatic test_glitch();
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
        idle(3);
    endtask

    task automatic test_vote_mask();
        // Data bit 2 is 0 in 0xCB; flip it for one cycle at its first capture.
        send_frame(8'hCB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3 * PS + S - 1, -1);
        idle(3);
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 40);
        idle(4);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        idle(3);
    endtask

    task automatic test_back_to_back();
        valid_cyc_q.delete();
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        idle(3);
        n_cmp++;
        if (valid_cyc_q.size() != 2) begin
            n_err++;
            $display("FAIL b2b_count: got %0d pulses want 2", valid_cyc_q.size());
        end else if (valid_cyc_q[1] - valid_cyc_q[0] != 10 * PS) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles want %0d", valid_cyc_q[1] - valid_cyc_q[0], 10 * PS);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop_err();
        test_glitch();
        test_vote_mask();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
